// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants for the register-file writeback scheduler.
//   XLEN     : register data width
//   REG_AW   : register address width
//   NUM_REGS : number of architectural registers (2**REG_AW)
//   ZERO_REG : index of the hard-wired zero register
// ptr_width() gives a safe index width for an N-entry vector (at least 1 bit).
package regfile_wb_scheduler_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 1 << REG_AW;
  localparam int ZERO_REG = 0;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter for the writeback sources.
// Ports:
//   clk      : clock
//   rst_n    : asynchronous active-low reset (pointer returns to 0)
//   req      : request vector, one bit per requester
//   en       : grants allowed this cycle
//   gnt      : one-hot grant, combinational
//   gnt_any  : some request was granted this cycle
// The grant goes to the first requesting index at or after the pointer; the
// pointer moves one past the winner on a grant and holds otherwise.
module rr_arbiter
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic         gnt_any
);

  localparam int PW = ptr_width(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = PW'((int'(ptr) + k) % N);
      if (en && !gnt_any && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        gnt_any   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler.
// Keeps a scoreboard of registers with an outstanding writeback, stalls issue
// on RAW/WAW hazards, and round-robin arbitrates NREQ writeback sources onto
// the single register-file write port (WE3/A3/WD3, one cycle of latency).
// Ports:
//   CLK, CLR_N        : clock, asynchronous active-low reset
//   FLUSH             : synchronous drop of all reservations
//   ISS_VALID/RS1/RS2/RD, ISS_STALL : issue slot and its stall
//   WB_VALID/RD/DATA, WB_READY      : packed writeback requesters and grant
//   WE3/A3/WD3        : registered register-file write port
//   PEND              : scoreboard (bit r = write to r outstanding)
//   ERR               : sticky, writeback to a non-pending register
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int XLEN = regfile_wb_scheduler_pkg::XLEN,
  parameter int AW   = REG_AW
) (
  input  logic                 CLK,
  input  logic                 CLR_N,
  input  logic                 FLUSH,
  input  logic                 ISS_VALID,
  input  logic [AW-1:0]        ISS_RS1,
  input  logic [AW-1:0]        ISS_RS2,
  input  logic [AW-1:0]        ISS_RD,
  output logic                 ISS_STALL,
  input  logic [NREQ-1:0]      WB_VALID,
  input  logic [NREQ*AW-1:0]   WB_RD,
  input  logic [NREQ*XLEN-1:0] WB_DATA,
  output logic [NREQ-1:0]      WB_READY,
  output logic                 WE3,
  output logic [AW-1:0]        A3,
  output logic [XLEN-1:0]      WD3,
  output logic [(1<<AW)-1:0]   PEND,
  output logic                 ERR
);

  localparam int NR = 1 << AW;

  logic [NR-1:0]   pend;
  logic [NR-1:0]   pend_n;
  logic            hazard;
  logic            iss_accept;
  logic [NREQ-1:0] gnt;
  logic            gnt_any;
  logic [AW-1:0]   gnt_rd;
  logic [XLEN-1:0] gnt_data;
  logic            gnt_rd_nz;

  // Hazard check uses the registered scoreboard only, so an operand unblocks
  // the cycle after its value has been written into the register file.
  assign hazard     = pend[ISS_RS1] | pend[ISS_RS2] | pend[ISS_RD];
  assign ISS_STALL  = CLR_N & ISS_VALID & ~FLUSH & hazard;
  assign iss_accept = ISS_VALID & ~ISS_STALL & ~FLUSH;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (CLK),
    .rst_n   (CLR_N),
    .req     (WB_VALID),
    .en      (CLR_N & ~FLUSH),
    .gnt     (gnt),
    .gnt_any (gnt_any)
  );

  assign WB_READY = gnt;

  always_comb begin
    gnt_rd   = '0;
    gnt_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_rd   = WB_RD[i*AW +: AW];
        gnt_data = WB_DATA[i*XLEN +: XLEN];
      end
    end
  end

  assign gnt_rd_nz = (gnt_rd != AW'(ZERO_REG));

  // Clear first, then set, so a same-edge set on the same bit wins.
  always_comb begin
    pend_n = pend;
    if (WE3) begin
      pend_n[A3] = 1'b0;
    end
    if (iss_accept && (ISS_RD != AW'(ZERO_REG))) begin
      pend_n[ISS_RD] = 1'b1;
    end
    if (FLUSH) begin
      pend_n = '0;
    end
    pend_n[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      pend <= '0;
    end else begin
      pend <= pend_n;
    end
  end

  assign PEND = pend;

  // A writeback to x0 is consumed without touching the write port; A3/WD3
  // keep their previous values in that case, as they do when idle.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      WE3 <= 1'b0;
      A3  <= '0;
      WD3 <= '0;
    end else if (gnt_any && gnt_rd_nz) begin
      WE3 <= 1'b1;
      A3  <= gnt_rd;
      WD3 <= gnt_data;
    end else begin
      WE3 <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      ERR <= 1'b0;
    end else if (gnt_any && gnt_rd_nz && !pend[gnt_rd]) begin
      ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

  logic        CLK;
  logic        CLR_N;
  logic        FLUSH;
  logic        ISS_VALID;
  logic [4:0]  ISS_RS1;
  logic [4:0]  ISS_RS2;
  logic [4:0]  ISS_RD;
  logic        ISS_STALL;
  logic [2:0]  WB_VALID;
  logic [14:0] WB_RD;
  logic [95:0] WB_DATA;
  logic [2:0]  WB_READY;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [31:0] PEND;
  logic        ERR;

  int checks = 0;
  int errors = 0;

  regfile_wb_scheduler #(.NREQ(3), .XLEN(32), .AW(5)) dut (
    .CLK       (CLK),
    .CLR_N     (CLR_N),
    .FLUSH     (FLUSH),
    .ISS_VALID (ISS_VALID),
    .ISS_RS1   (ISS_RS1),
    .ISS_RS2   (ISS_RS2),
    .ISS_RD    (ISS_RD),
    .ISS_STALL (ISS_STALL),
    .WB_VALID  (WB_VALID),
    .WB_RD     (WB_RD),
    .WB_DATA   (WB_DATA),
    .WB_READY  (WB_READY),
    .WE3       (WE3),
    .A3        (A3),
    .WD3       (WD3),
    .PEND      (PEND),
    .ERR       (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_wb(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
    WB_VALID[i]        = v;
    WB_RD[i*5 +: 5]    = rd;
    WB_DATA[i*32 +: 32] = d;
  endtask

  task automatic set_iss(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    ISS_VALID = v;
    ISS_RS1   = rs1;
    ISS_RS2   = rs2;
    ISS_RD    = rd;
  endtask

  task automatic reserve(input logic [4:0] rd);
    set_iss(1'b1, 5'd0, 5'd0, rd);
    step();
    set_iss(1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic apply_reset();
    CLR_N = 1'b0;
    step();
    CLR_N = 1'b1;
    step();
  endtask

  task automatic test_reset();
    CLR_N = 1'b0;
    FLUSH = 1'b0;
    set_iss(1'b1, 5'd5, 5'd6, 5'd7);
    WB_VALID = 3'b111;
    WB_RD = '0;
    WB_DATA = '0;
    step();
    step();
    @(negedge CLK);
    checks++; if (PEND !== 32'h0) begin errors++; $display("FAIL reset_pend got %h exp %h", PEND, 32'h0); end
    checks++; if ({WE3, A3, WD3} !== 38'h0) begin errors++; $display("FAIL reset_wport got %b/%h/%h exp 0", WE3, A3, WD3); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", ERR); end
    checks++; if (WB_READY !== 3'b000) begin errors++; $display("FAIL reset_ready got %b exp 000", WB_READY); end
    checks++; if (ISS_STALL !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", ISS_STALL); end
    step();
    set_iss(1'b0, 5'd0, 5'd0, 5'd0);
    WB_VALID = 3'b000;
    CLR_N = 1'b1;
    step();
  endtask

  task automatic test_hazard();
    set_iss(1'b1, 5'd0, 5'd0, 5'd5);
    @(negedge CLK);
    checks++; if (ISS_STALL !== 1'b0) begin errors++; $display("FAIL hz_first_stall got %b exp 0", ISS_STALL); end
    step();
    set_iss(1'b1, 5'd5, 5'd0, 5'd9);
    @(negedge CLK);
    checks++; if (PEND !== 32'h0000_0020) begin errors++; $display("FAIL hz_pend5 got %h exp %h", PEND, 32'h20); end
    checks++; if (ISS_STALL !== 1'b1) begin errors++; $display("FAIL hz_raw_stall got %b exp 1", ISS_STALL); end
    step();
    set_iss(1'b0, 5'd0, 5'd0, 5'd0);
    set_wb(0, 1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge CLK);
    checks++; if (WB_READY !== 3'b001) begin errors++; $display("FAIL hz_ready got %b exp 001", WB_READY); end
    step();
    set_wb(0, 1'b0, 5'd0, 32'h0);
    set_iss(1'b1, 5'd5, 5'd0, 5'd0);
    @(negedge CLK);
    checks++; if ({WE3, A3, WD3} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin errors++; $display("FAIL hz_write got %b/%h/%h exp 1/05/deadbeef", WE3, A3, WD3); end
    checks++; if (ISS_STALL !== 1'b1) begin errors++; $display("FAIL hz_still_stall got %b exp 1", ISS_STALL); end
    checks++; if (PEND !== 32'h0000_0020) begin errors++; $display("FAIL hz_no_rd9 got %h exp %h", PEND, 32'h20); end
    step();
    @(negedge CLK);
    checks++; if (PEND !== 32'h0) begin errors++; $display("FAIL hz_cleared got %h exp 0", PEND); end
    checks++; if (ISS_STALL !== 1'b0) begin errors++; $display("FAIL hz_unstall got %b exp 0", ISS_STALL); end
    checks++; if ({WE3, A3} !== {1'b0, 5'd5}) begin errors++; $display("FAIL hz_idle_hold got %b/%h exp 0/05", WE3, A3); end
    step();
    set_iss(1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic test_round_robin();
    apply_reset();
    reserve(5'd1);
    reserve(5'd2);
    reserve(5'd3);
    reserve(5'd4);
    reserve(5'd6);
    set_wb(0, 1'b1, 5'd1, 32'hA1);
    set_wb(1, 1'b1, 5'd2, 32'hB2);
    set_wb(2, 1'b1, 5'd3, 32'hC3);
    @(negedge CLK);
    checks++; if (WB_READY !== 3'b001) begin errors++; $display("FAIL rr_g0 got %b exp 001", WB_READY); end
    step();
    set_wb(0, 1'b0, 5'd0, 32'h0);
    @(negedge CLK);
    checks++; if (WB_READY !== 3'b010) begin errors++; $display("FAIL rr_g1 got %b exp 010", WB_READY); end
    checks++; if ({WE3, A3, WD3} !== {1'b1, 5'd1, 32'hA1}) begin errors++; $display("FAIL rr_w1 got %b/%h/%h exp 1/01/a1", WE3, A3, WD3); end
    step();
    set_wb(1, 1'b0, 5'd0, 32'h0);
    @(negedge CLK);
    checks++; if (WB_READY !== 3'b100) begin errors++; $display("FAIL rr_g2 got %b exp 100", WB_READY); end
    checks++; if ({WE3, A3, WD3} !== {1'b1, 5'd2, 32'hB2}) begin errors++; $display("FAIL rr_w2 got %b/%h/%h exp 1/02/b2", WE3, A3, WD3); end
    step();
    set_wb(2, 1'b0, 5'd0, 32'h0);
    set_wb(0, 1'b1, 5'd4, 32'hD4);
    set_wb(1, 1'b1, 5'd6, 32'hE6);
    @(negedge CLK);
    checks++; if (WB_READY !== 3'b001) begin errors++; $display("FAIL rr_g0_again got %b exp 001", WB_READY); end
    checks++; if ({WE3, A3, WD3} !== {1'b1, 5'd3, 32'hC3}) begin errors++; $display("FAIL rr_w3 got %b/%h/%h exp 1/03/c3", WE3, A3, WD3); end
    step();
    set_wb(0, 1'b0, 5'd0, 32'h0);
    @(negedge CLK);
    checks++; if (WB_READY !== 3'b010) begin errors++; $display("FAIL rr_g1_again got %b exp 010", WB_READY); end
    step();
    set_wb(1, 1'b0, 5'd0, 32'h0);
    @(negedge CLK);
    checks++; if ({WE3, A3, WD3} !== {1'b1, 5'd6, 32'hE6}) begin errors++; $display("FAIL rr_w6 got %b/%h/%h exp 1/06/e6", WE3, A3, WD3); end
    step();
    step();
    @(negedge CLK);
    checks++; if (PEND !== 32'h0) begin errors++; $display("FAIL rr_pend_drain got %h exp 0", PEND); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL rr_err got %b exp 0", ERR); end
  endtask

  task automatic test_rd_zero();
    reserve(5'd0);
    @(negedge CLK);
    checks++; if (PEND !== 32'h0) begin errors++; $display("FAIL z_pend got %h exp 0", PEND); end
    set_wb(2, 1'b1, 5'd0, 32'h55);
    @(negedge CLK);
    checks++; if (WB_READY !== 3'b100) begin errors++; $display("FAIL z_ready got %b exp 100", WB_READY); end
    step();
    set_wb(2, 1'b0, 5'd0, 32'h0);
    @(negedge CLK);
    checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL z_we3 got %b exp 0", WE3); end
    checks++; if (A3 !== 5'd6) begin errors++; $display("FAIL z_a3_hold got %h exp 06", A3); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL z_err got %b exp 0", ERR); end
    step();
  endtask

  task automatic test_err();
    set_wb(1, 1'b1, 5'd7, 32'h77);
    @(negedge CLK);
    checks++; if (WB_READY !== 3'b010) begin errors++; $display("FAIL e_ready got %b exp 010", WB_READY); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL e_before got %b exp 0", ERR); end
    step();
    set_wb(1, 1'b0, 5'd0, 32'h0);
    @(negedge CLK);
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL e_set got %b exp 1", ERR); end
    checks++; if ({WE3, A3} !== {1'b1, 5'd7}) begin errors++; $display("FAIL e_write got %b/%h exp 1/07", WE3, A3); end
    reserve(5'd8);
    set_wb(0, 1'b1, 5'd8, 32'h88);
    step();
    set_wb(0, 1'b0, 5'd0, 32'h0);
    step();
    @(negedge CLK);
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL e_sticky got %b exp 1", ERR); end
    checks++; if (PEND !== 32'h0) begin errors++; $display("FAIL e_pend got %h exp 0", PEND); end
  endtask

  task automatic test_flush();
    reserve(5'd3);
    reserve(5'd4);
    set_wb(0, 1'b1, 5'd3, 32'h33);
    @(negedge CLK);
    checks++; if (PEND !== 32'h0000_0018) begin errors++; $display("FAIL f_pend_pre got %h exp %h", PEND, 32'h18); end
    checks++; if (WB_READY !== 3'b001) begin errors++; $display("FAIL f_ready_pre got %b exp 001", WB_READY); end
    step();
    set_wb(0, 1'b0, 5'd0, 32'h0);
    set_wb(1, 1'b1, 5'd4, 32'h44);
    FLUSH = 1'b1;
    set_iss(1'b1, 5'd3, 5'd0, 5'd11);
    @(negedge CLK);
    checks++; if (WB_READY !== 3'b000) begin errors++; $display("FAIL f_ready_flush got %b exp 000", WB_READY); end
    checks++; if (ISS_STALL !== 1'b0) begin errors++; $display("FAIL f_stall_flush got %b exp 0", ISS_STALL); end
    checks++; if ({WE3, A3, WD3} !== {1'b1, 5'd3, 32'h33}) begin errors++; $display("FAIL f_write got %b/%h/%h exp 1/03/33", WE3, A3, WD3); end
    step();
    FLUSH = 1'b0;
    set_iss(1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge CLK);
    checks++; if (PEND !== 32'h0) begin errors++; $display("FAIL f_pend_post got %h exp 0", PEND); end
    checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL f_we3_post got %b exp 0", WE3); end
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL f_err_kept got %b exp 1", ERR); end
    checks++; if (WB_READY !== 3'b010) begin errors++; $display("FAIL f_ready_post got %b exp 010", WB_READY); end
    step();
    set_wb(1, 1'b0, 5'd0, 32'h0);
    step();
  endtask

  task automatic test_async_reset();
    reserve(5'd10);
    set_wb(2, 1'b1, 5'd10, 32'hA5A5_0001);
    step();
    set_wb(2, 1'b0, 5'd0, 32'h0);
    set_wb(0, 1'b1, 5'd10, 32'h1234);
    #1;
    checks++; if ({WE3, A3, PEND[10]} !== {1'b1, 5'd10, 1'b1}) begin errors++; $display("FAIL ar_pre got %b/%h/%b exp 1/0a/1", WE3, A3, PEND[10]); end
    CLR_N = 1'b0;
    #1;
    checks++; if ({WE3, A3, WD3} !== 38'h0) begin errors++; $display("FAIL ar_wport got %b/%h/%h exp 0", WE3, A3, WD3); end
    checks++; if ({PEND, ERR} !== 33'h0) begin errors++; $display("FAIL ar_pend_err got %h/%b exp 0/0", PEND, ERR); end
    checks++; if (WB_READY !== 3'b000) begin errors++; $display("FAIL ar_ready got %b exp 000", WB_READY); end
    step();
    checks++; if ({WE3, PEND} !== 33'h0) begin errors++; $display("FAIL ar_held got %b/%h exp 0/0", WE3, PEND); end
    set_wb(0, 1'b0, 5'd0, 32'h0);
    CLR_N = 1'b1;
    step();
    @(negedge CLK);
    checks++; if ({WE3, ERR} !== 2'b00) begin errors++; $display("FAIL ar_after got %b/%b exp 0/0", WE3, ERR); end
  endtask

  initial begin
    test_reset();
    test_hazard();
    test_round_robin();
    test_rd_zero();
    test_err();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
